fp_mac_result_buffer: RTL and testbench
=======================================

# fp_mac_result_buffer

Result buffer directly downstream of the FP MAC wrapper. It captures every single-cycle result pulse (result, tag, status flags) into a small FIFO, because the MAC unit cannot be stalled. It presents the results to the APU interconnect with a valid/ack handshake. An issue-credit counter drives the ready line seen by the issue stage, so a result can never arrive at a full buffer, whatever the MAC pipeline depth.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- FP_WIDTH, 32: result width.
- TAG_WIDTH, WAPUTAG: tag width.
- STAT_WIDTH, NUSFLAGS_MAC: status-flag width.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- Issue_i  in  1  issue stage launches one op into the MAC this cycle (MAC En_i).
- IssueReady_o  out  1  a credit is available; issue stage may launch.
- Valid_i  in  1  MAC result valid (single-cycle pulse, no backpressure).
- Res_i  in  FP_WIDTH  MAC result.
- Tag_i  in  TAG_WIDTH  MAC tag.
- Status_i  in  STAT_WIDTH  MAC status flags.
- Valid_o  out  1  head entry valid.
- Res_o  out  FP_WIDTH  head result.
- Tag_o  out  TAG_WIDTH  head tag.
- Status_o  out  STAT_WIDTH  head status.
- Ack_i  in  1  consumer takes the head entry.
- Level_o  out  $clog2(DEPTH+1)  FIFO occupancy.
- Overflow_o  out  1  sticky error: a result was dropped or an issue was made without credit.

## Operation
- Storage:
  - DEPTH-entry circular FIFO of {Res, Tag, Status}.
  - Write and read pointers of $clog2(DEPTH) bits wrap naturally.
  - Occupancy counter is 0..DEPTH.
- Push: Valid_i && (Level_o < DEPTH || pop).
  - A push at full is allowed when it coincides with a pop.
- Pop: Valid_o && Ack_i.
  - Ack_i while Valid_o=0 is ignored.
- Dropped result: Valid_i while full and not popping.
  - Result is discarded; Overflow_o is set.
- Head outputs: Valid_o = (Level_o != 0).
  - Res_o/Tag_o/Status_o read the entry at the read pointer.
  - Contents are meaningful only while Valid_o=1.
- Credit counter Reserved (0..DEPTH) = FIFO entries + ops in flight in the MAC.
  - Increments on an accepted issue: Issue_i && IssueReady_o.
  - Decrements on pop.
  - Simultaneous accepted issue and pop: unchanged.
  - Dropped results do not change Reserved.
- IssueReady_o = (Reserved < DEPTH), combinational from the registered counter.
- Issue_i while IssueReady_o=0:
  - Not counted.
  - Overflow_o is set.
  - The op is not blocked; blocking is the issue stage's responsibility.
- Overflow_o clears only on reset.
- Reset mid-operation:
  - Immediately empties the FIFO and zeroes Reserved, pointers and Overflow_o.
  - MAC results still in flight and arriving after reset release are accepted as new entries. The issue stage must flush the MAC alongside this block.

## Timing
- Latency from Valid_i to Valid_o is 1 cycle, with no bypass.
  - Result captured at edge N is visible at Valid_o after edge N.
- Pop takes effect at the clock edge where Valid_o && Ack_i.
  - The next entry, if any, is presented in the following cycle.
  - Back-to-back acks drain one entry per cycle.
- Push and pop in the same cycle: Level_o unchanged, both pointers advance.
- Credit return timing:
  - A pop at edge N makes IssueReady_o rise after edge N.
  - The issue stage may launch in cycle N+1.
- Reset values:
  - Valid_o=0, Res_o/Tag_o/Status_o=0 (all storage reset to 0).
  - Level_o=0, Overflow_o=0, IssueReady_o=1.

## Test plan
- Single op:
  - Stimulus: reset; Issue_i pulse; 3 cycles later Valid_i with Res_i=0x3F800000, Tag_i=5, Status_i=0.
  - Required: Valid_o=1 one cycle later with the same values. Ack_i → Valid_o=0, Level_o=0, IssueReady_o=1.
- Credit exhaustion (DEPTH=4):
  - Stimulus: 4 back-to-back issues with no Ack_i.
  - Required: IssueReady_o=0 after the 4th issue. The 4 results fill the FIFO, Level_o=4, Overflow_o=0. One Ack_i → IssueReady_o=1 next cycle.
- Push and pop at full:
  - Stimulus: FIFO holds tags 1-4; same cycle Valid_i with tag 6 and Ack_i.
  - Required: Level_o stays 4, Tag_o=2 next cycle, no overflow. Draining yields order 2,3,4,6.
- Wrap-around:
  - Stimulus: 10 results with tags 0..9, each acked 2 cycles after arrival.
  - Required: output tag order 0..9 across pointer wrap, Level_o never exceeds 2.
- Error flags:
  - Stimulus 1: Valid_i at full without ack. Required: entry dropped, Overflow_o=1, Level_o=4.
  - Stimulus 2: after a reset, Issue_i while IssueReady_o=0. Required: Overflow_o=1, Reserved unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_i asynchronously with Level_o=3.
  - Required: Valid_o=0, Level_o=0, IssueReady_o=1, Overflow_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fp_mac_result_buffer.sv
// Result buffer behind the FP MAC: captures unstallable result pulses into a FIFO
// and hands out issue credits so that a result never meets a full buffer.
module fp_mac_result_buffer #(
   parameter int DEPTH      = 4,
   parameter int FP_WIDTH   = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int STAT_WIDTH = 5,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int LVL_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  Issue_i,
   output logic                  IssueReady_o,
   input  logic                  Valid_i,
   input  logic [FP_WIDTH-1:0]   Res_i,
   input  logic [TAG_WIDTH-1:0]  Tag_i,
   input  logic [STAT_WIDTH-1:0] Status_i,
   output logic                  Valid_o,
   output logic [FP_WIDTH-1:0]   Res_o,
   output logic [TAG_WIDTH-1:0]  Tag_o,
   output logic [STAT_WIDTH-1:0] Status_o,
   input  logic                  Ack_i,
   output logic [LVL_W-1:0]      Level_o,
   output logic                  Overflow_o
);

   logic [FP_WIDTH-1:0]   res_q  [DEPTH];
   logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
   logic [STAT_WIDTH-1:0] stat_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [LVL_W-1:0]      level;
   logic [LVL_W-1:0]      reserved;
   logic                  overflow;

   logic full;
   logic push;
   logic pop;
   logic drop;
   logic issue_acc;
   logic issue_bad;
   logic credit_ret;

   // Handshake: the head entry leaves on the edge where Valid_o && Ack_i; Ack_i
   // with Valid_o low is ignored. Valid_i has no backpressure, so a result
   // arriving at a full, non-popping buffer is dropped and flagged.
   assign full       = (level == LVL_W'(DEPTH));
   assign pop        = Valid_o && Ack_i;
   assign push       = Valid_i && (!full || pop);
   assign drop       = Valid_i && !push;
   assign issue_acc  = Issue_i && IssueReady_o;
   assign issue_bad  = Issue_i && !IssueReady_o;
   // Stray results (e.g. in flight across a reset) hold no credit, so never underflow.
   assign credit_ret = pop && (reserved != '0);

   assign Valid_o      = (level != '0);
   assign Res_o        = res_q[rd_ptr];
   assign Tag_o        = tag_q[rd_ptr];
   assign Status_o     = stat_q[rd_ptr];
   assign Level_o      = level;
   assign Overflow_o   = overflow;
   assign IssueReady_o = (reserved < LVL_W'(DEPTH));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            res_q[i]  <= '0;
            tag_q[i]  <= '0;
            stat_q[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         reserved <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            res_q[wr_ptr]  <= Res_i;
            tag_q[wr_ptr]  <= Tag_i;
            stat_q[wr_ptr] <= Status_i;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            level <= level + LVL_W'(1);
         end else if (pop && !push) begin
            level <= level - LVL_W'(1);
         end
         if (issue_acc && !credit_ret) begin
            reserved <= reserved + LVL_W'(1);
         end else if (credit_ret && !issue_acc) begin
            reserved <= reserved - LVL_W'(1);
         end
         if (drop || issue_bad) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fp_mac_result_buffer.sv
// Directed bench for fp_mac_result_buffer: stimulus queues expected head entries,
// a negedge monitor pops and compares on every accepted ack.
module tb_fp_mac_result_buffer;

   localparam int DEPTH = 4;
   localparam int FPW   = 32;
   localparam int TW    = 4;
   localparam int SW    = 5;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          Issue_i = 1'b0;
   logic          IssueReady_o;
   logic          Valid_i = 1'b0;
   logic [FPW-1:0] Res_i = '0;
   logic [TW-1:0]  Tag_i = '0;
   logic [SW-1:0]  Status_i = '0;
   logic          Valid_o;
   logic [FPW-1:0] Res_o;
   logic [TW-1:0]  Tag_o;
   logic [SW-1:0]  Status_o;
   logic          Ack_i = 1'b0;
   logic [LW-1:0]  Level_o;
   logic          Overflow_o;

   int errors = 0;
   int checks = 0;
   logic [FPW+TW+SW-1:0] exp_q[$];

   fp_mac_result_buffer #(.DEPTH(DEPTH), .FP_WIDTH(FPW), .TAG_WIDTH(TW), .STAT_WIDTH(SW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .Issue_i(Issue_i), .IssueReady_o(IssueReady_o),
      .Valid_i(Valid_i), .Res_i(Res_i), .Tag_i(Tag_i), .Status_i(Status_i),
      .Valid_o(Valid_o), .Res_o(Res_o), .Tag_o(Tag_o), .Status_o(Status_o),
      .Ack_i(Ack_i), .Level_o(Level_o), .Overflow_o(Overflow_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // driver: one cycle of result/ack, queuing the entry if it should be accepted
   task automatic send(input logic v, input logic [FPW-1:0] res, input logic [TW-1:0] tag,
                       input logic [SW-1:0] st, input logic ack, input bit accept);
      Valid_i  = v;
      Res_i    = res;
      Tag_i    = tag;
      Status_i = st;
      Ack_i    = ack;
      if (v && accept) exp_q.push_back({res, tag, st});
      tick();
      Valid_i = 1'b0;
      Ack_i   = 1'b0;
   endtask

   task automatic issue(input int n);
      for (int i = 0; i < n; i++) begin
         Issue_i = 1'b1;
         tick();
      end
      Issue_i = 1'b0;
   endtask

   task automatic ack_n(input int n);
      for (int i = 0; i < n; i++) begin
         Ack_i = 1'b1;
         tick();
      end
      Ack_i = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk_i) begin
      if (!rst_i && Valid_o && Ack_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL head_pop: got tag 0x%0h with empty expected queue", Tag_o);
         end else begin
            logic [FPW+TW+SW-1:0] e;
            e = exp_q.pop_front();
            if ({Res_o, Tag_o, Status_o} !== e) begin
               errors++;
               $display("FAIL head_pop: got res 0x%0h tag 0x%0h st 0x%0h expected res 0x%0h tag 0x%0h st 0x%0h",
                        Res_o, Tag_o, Status_o, e[FPW+TW+SW-1:TW+SW], e[TW+SW-1:SW], e[SW-1:0]);
            end
         end
      end
   end

   initial begin
      int max_lvl;
      // reset state
      tick(); tick();
      check("rst_valid", 32'(Valid_o), 0);
      check("rst_level", 32'(Level_o), 0);
      check("rst_ovf", 32'(Overflow_o), 0);
      check("rst_ready", 32'(IssueReady_o), 1);
      check("rst_res", Res_o, 0);
      check("rst_tag", 32'(Tag_o), 0);
      rst_i = 1'b0;
      tick();

      // single op
      issue(1);
      check("one_ready", 32'(IssueReady_o), 1);
      tick(); tick();
      send(1'b1, 32'h3F80_0000, 4'd5, 5'd0, 1'b0, 1'b1);
      check("one_valid", 32'(Valid_o), 1);
      check("one_res", Res_o, 32'h3F80_0000);
      check("one_tag", 32'(Tag_o), 5);
      check("one_level", 32'(Level_o), 1);
      ack_n(1);
      check("one_valid_after", 32'(Valid_o), 0);
      check("one_level_after", 32'(Level_o), 0);
      check("one_ready_after", 32'(IssueReady_o), 1);
      ack_n(1);
      check("ack_empty_level", 32'(Level_o), 0);

      // credit exhaustion
      issue(3);
      check("cred_ready3", 32'(IssueReady_o), 1);
      issue(1);
      check("cred_ready4", 32'(IssueReady_o), 0);
      for (int t = 1; t <= 4; t++) send(1'b1, 32'h4000_0000 + t, TW'(t), SW'(t), 1'b0, 1'b1);
      check("cred_level", 32'(Level_o), 4);
      check("cred_ovf", 32'(Overflow_o), 0);
      check("cred_ready_full", 32'(IssueReady_o), 0);
      ack_n(1);
      check("cred_ready_ret", 32'(IssueReady_o), 1);
      check("cred_level3", 32'(Level_o), 3);
      ack_n(3);
      check("cred_drained", 32'(Level_o), 0);

      // push and pop at full
      issue(4);
      for (int t = 1; t <= 4; t++) send(1'b1, 32'h4100_0000 + t, TW'(t), 5'd1, 1'b0, 1'b1);
      send(1'b1, 32'h4100_0006, 4'd6, 5'd2, 1'b1, 1'b1);
      check("pp_level", 32'(Level_o), 4);
      check("pp_tag", 32'(Tag_o), 2);
      check("pp_ovf", 32'(Overflow_o), 0);
      check("pp_ready", 32'(IssueReady_o), 1);
      ack_n(4);
      check("pp_drained", 32'(Level_o), 0);
      check("pp_ready_drained", 32'(IssueReady_o), 1);

      // wrap-around: arrival every cycle, ack two cycles after arrival
      max_lvl = 0;
      for (int c = 0; c < 12; c++) begin
         send(c < 10, 32'h4200_0000 + c, TW'(c), SW'(c), c >= 2, 1'b1);
         if (int'(Level_o) > max_lvl) max_lvl = int'(Level_o);
      end
      check("wrap_max_level", 32'(max_lvl), 2);
      check("wrap_level_end", 32'(Level_o), 0);
      check("wrap_q_empty", 32'(exp_q.size()), 0);

      // dropped result at full
      issue(4);
      for (int t = 0; t < 4; t++) send(1'b1, 32'h4300_0000 + t, TW'(t + 8), 5'd3, 1'b0, 1'b1);
      check("drop_pre_ovf", 32'(Overflow_o), 0);
      send(1'b1, 32'h4300_00FF, 4'd15, 5'd4, 1'b0, 1'b0);
      check("drop_ovf", 32'(Overflow_o), 1);
      check("drop_level", 32'(Level_o), 4);
      ack_n(1);
      issue(1);
      check("mid_level3", 32'(Level_o), 3);
      check("mid_ready0", 32'(IssueReady_o), 0);

      // asynchronous reset mid-cycle
      #2 rst_i = 1'b1;
      #1;
      check("arst_valid", 32'(Valid_o), 0);
      check("arst_level", 32'(Level_o), 0);
      check("arst_ready", 32'(IssueReady_o), 1);
      check("arst_ovf", 32'(Overflow_o), 0);
      exp_q.delete();
      tick();
      rst_i = 1'b0;
      tick();

      // issue without credit
      issue(4);
      check("nc_ready0", 32'(IssueReady_o), 0);
      check("nc_ovf0", 32'(Overflow_o), 0);
      issue(1);
      check("nc_ovf1", 32'(Overflow_o), 1);
      check("nc_ready_still0", 32'(IssueReady_o), 0);
      send(1'b1, 32'h4400_0001, 4'd7, 5'd9, 1'b0, 1'b1);
      ack_n(1);
      check("nc_ready_after_pop", 32'(IssueReady_o), 1);
      check("final_q_empty", 32'(exp_q.size()), 0);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
